i2c_arbiter: RTL

Shares a single I2C register-write engine (the single-register write handler used for clock-chip configuration) between up to NUM_REQ runtime requesters, e.g. host-driven LMK61E2 divider updates, ADC front-end gain writes and debug pokes. Arbitration is round-robin with per-requester completion and error reporting plus a busy-watchdog. The block sits between the requesters and the engine. It is held off by `enable` until the power-up configuration sequencer reports done.

---
 rtl/i2c_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
//
// Purpose:
//   Shares one single-register I2C write engine between NUM_REQ runtime
//   requesters (clock-chip divider updates, ADC gain writes, debug pokes).
//   Round-robin arbitration, per-requester ack/error reporting and a busy
//   watchdog that forces completion if the engine never releases eng_busy.
//   New grants are held off until `enable` (power-up config done) is high.
//
// State table:
//   IDLE     | waiting for enable & a valid request & idle engine
//   LAUNCH   | eng_start pulse, fields already captured
//   WAIT     | one cycle for the engine to raise eng_busy
//   RUN      | engine working; accumulate NACK, run watchdog
//   COMPLETE | ack (and error) to the granted requester for one cycle
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            arbitration permitted
//   req_valid         per-requester request pending
//   req_address       7-bit slave address, requester i at [7i+6:7i]
//   req_reg_address   register address, requester i at [8i+7:8i]
//   req_data          write data, requester i at [8i+7:8i]
//   req_grant         one-hot, high from grant until ack inclusive
//   req_ack           one-cycle completion pulse to the granted requester
//   req_error         qualifies req_ack: engine NACK or watchdog expiry
//   eng_start         one-cycle start pulse to the engine
//   eng_address       captured slave address
//   eng_reg_address   captured register address
//   eng_data          captured write data
//   eng_busy          engine transaction in progress
//   eng_nack          engine saw a NACK (meaningful while eng_busy)
//   arb_busy          arbiter not idle
//   timeout_flag      sticky watchdog-expiry flag, cleared only by reset
// ---------------------------------------------------------------------------
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [7*NUM_REQ-1:0]   req_address,
  input  logic [8*NUM_REQ-1:0]   req_reg_address,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_error,
  output logic                   eng_start,
  output logic [6:0]             eng_address,
  output logic [7:0]             eng_reg_address,
  output logic [7:0]             eng_data,
  input  logic                   eng_busy,
  input  logic                   eng_nack,
  output logic                   arb_busy,
  output logic                   timeout_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT     = 3'd2,
    S_RUN      = 3'd3,
    S_COMPLETE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_acc_q, err_acc_d;
  logic                 error_q, error_d;
  logic                 tflag_q, tflag_d;
  logic [6:0]           eng_addr_q, eng_addr_d;
  logic [7:0]           eng_reg_q, eng_reg_d;
  logic [7:0]           eng_data_q, eng_data_d;

  // Round-robin winner: first valid bit after last_grant, wrapping.
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [6:0]           sel_addr;
  logic [7:0]           sel_reg;
  logic [7:0]           sel_data;

  always_comb begin
    int sum;
    logic [IDX_W-1:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = 0;
    pos       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = (int'(last_grant_q) + k) % NUM_REQ;
      pos = sum[IDX_W-1:0];
      if (!win_found && req_valid[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_addr = req_address[7*i +: 7];
        sel_reg  = req_reg_address[8*i +: 8];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    err_acc_d    = err_acc_q;
    error_d      = error_q;
    tflag_d      = tflag_q;
    eng_addr_d   = eng_addr_q;
    eng_reg_d    = eng_reg_q;
    eng_data_d   = eng_data_q;

    case (state_q)
      S_IDLE: begin
        // eng_busy here means the power-up sequencer still owns the engine.
        if (enable && (|req_valid) && !eng_busy && win_found) begin
          state_d          = S_LAUNCH;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_grant_d     = win_idx;
          eng_addr_d       = sel_addr;
          eng_reg_d        = sel_reg;
          eng_data_d       = sel_data;
          err_acc_d        = 1'b0;
          error_d          = 1'b0;
          wd_d             = '0;
        end
      end

      S_LAUNCH: state_d = S_WAIT;

      S_WAIT: state_d = S_RUN;

      S_RUN: begin
        wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        err_acc_d = err_acc_q | (eng_nack & eng_busy);
        if (!eng_busy) begin
          state_d = S_COMPLETE;
          error_d = err_acc_q;
        end else if (wd_q >= WD_LAST) begin
          state_d = S_COMPLETE;
          error_d = 1'b1;
          tflag_d = 1'b1;
        end
      end

      S_COMPLETE: begin
        state_d = S_IDLE;
        grant_d = '0;
        error_d = 1'b0;
      end

      default: begin
        // Corrupted encoding: drop everything except the sticky flag.
        state_d      = S_IDLE;
        grant_d      = '0;
        last_grant_d = LAST_RST;
        wd_d         = '0;
        err_acc_d    = 1'b0;
        error_d      = 1'b0;
        eng_addr_d   = '0;
        eng_reg_d    = '0;
        eng_data_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      wd_q         <= '0;
      err_acc_q    <= 1'b0;
      error_q      <= 1'b0;
      tflag_q      <= 1'b0;
      eng_addr_q   <= '0;
      eng_reg_q    <= '0;
      eng_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      err_acc_q    <= err_acc_d;
      error_q      <= error_d;
      tflag_q      <= tflag_d;
      eng_addr_q   <= eng_addr_d;
      eng_reg_q    <= eng_reg_d;
      eng_data_q   <= eng_data_d;
    end
  end

  // Outputs decoded from state so an illegal encoding shows reset values.
  always_comb begin
    req_grant = '0;
    req_ack   = '0;
    req_error = '0;
    eng_start = 1'b0;
    arb_busy  = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_LAUNCH: begin
        req_grant = grant_q;
        eng_start = 1'b1;
        arb_busy  = 1'b1;
      end
      S_WAIT, S_RUN: begin
        req_grant = grant_q;
        arb_busy  = 1'b1;
      end
      S_COMPLETE: begin
        req_grant = grant_q;
        req_ack   = grant_q;
        req_error = error_q ? grant_q : '0;
        arb_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign eng_address     = eng_addr_q;
  assign eng_reg_address = eng_reg_q;
  assign eng_data        = eng_data_q;
  assign timeout_flag    = tflag_q;

endmodule
